// File: rtl/display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : display_scheduler
//  Purpose  : Time-multiplexes the 4-digit seven-segment display among five
//             game sources (bet, player, split, dealer, coin). Active
//             requesters are served round-robin. Each page is held for DWELL
//             unfrozen cycles, and the source value is snapshotted at page
//             entry and converted to glyph codes.
//  Ports    : clk, reset (async, active-high)
//             req[4:0]   level requests: 0 bet, 1 player, 2 split, 3 dealer,
//                        4 coin
//             freeze     holds the dwell counter while high (SHOW only)
//             bet, player_score/card, split_score/card, dealer_score, coin
//                        source values
//             d3..d0     registered glyph codes, d3 leftmost
//             page       shown source index, 7 when idle
//             page_start one-cycle pulse on the first cycle of each page
//  Revision : 1.0  initial release
// ============================================================================
module display_scheduler #(
    parameter int unsigned DWELL = 100_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic       freeze,
    input  logic [3:0] bet,
    input  logic [5:0] player_score,
    input  logic [5:0] player_card,
    input  logic [5:0] split_score,
    input  logic [5:0] split_card,
    input  logic [5:0] dealer_score,
    input  logic [4:0] coin,
    output logic [3:0] d3,
    output logic [3:0] d2,
    output logic [3:0] d1,
    output logic [3:0] d0,
    output logic [2:0] page,
    output logic       page_start
);

    localparam int unsigned   c_cnt_w    = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DWELL - 1);

    localparam logic [3:0] c_g_b     = 4'hA;
    localparam logic [3:0] c_g_d     = 4'hB;
    localparam logic [3:0] c_g_a     = 4'hC;
    localparam logic [3:0] c_g_blank = 4'hD;
    localparam logic [2:0] c_no_page = 3'd7;

    // ARM is the one-cycle gap between seeing a request in IDLE and showing
    // the page; the selection is captured on entry to ARM.
    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_arm  = 2'd1;
    localparam logic [1:0] c_st_show = 2'd2;

    logic [1:0]         r_state;
    logic [c_cnt_w-1:0] r_cnt;
    logic [2:0]         r_ptr;
    logic [2:0]         r_sel;

    logic [2:0]  w_start;
    logic [3:0]  w_idx;
    logic        w_found;
    logic [2:0]  w_sel;
    logic        w_load;
    logic [2:0]  w_load_idx;
    logic [15:0] w_glyph;

    // Two-digit field by repeated subtraction (v <= 63 so six steps suffice);
    // tens digit blanks below 10.
    function automatic logic [7:0] f_field(input logic [5:0] v);
        logic [5:0] rem;
        logic [3:0] tens;
        rem  = v;
        tens = 4'd0;
        for (int i = 0; i < 6; i++) begin
            if (rem >= 6'd10) begin
                rem  = rem - 6'd10;
                tens = tens + 4'd1;
            end
        end
        return {((v < 6'd10) ? c_g_blank : tens), rem[3:0]};
    endfunction

    // Round-robin search starting just after the last shown index.
    always_comb begin
        w_start = (r_ptr >= 3'd4) ? 3'd0 : r_ptr + 3'd1;
        w_found = 1'b0;
        w_sel   = 3'd0;
        w_idx   = 4'd0;
        for (int i = 0; i < 5; i++) begin
            w_idx = {1'b0, w_start} + 4'(i);
            if (w_idx >= 4'd5) begin
                w_idx = w_idx - 4'd5;
            end
            if (!w_found && req[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[2:0];
            end
        end
    end

    assign w_load = (r_state == c_st_arm) ||
                    ((r_state == c_st_show) && !freeze &&
                     (r_cnt == c_cnt_last) && w_found);

    assign w_load_idx = (r_state == c_st_arm) ? r_sel : w_sel;

    always_comb begin
        w_glyph = {4{c_g_blank}};
        case (w_load_idx)
            3'd0:    w_glyph = {c_g_b, c_g_blank, f_field({2'b00, bet})};
            3'd1:    w_glyph = {f_field(player_card), f_field(player_score)};
            3'd2:    w_glyph = {f_field(split_card), f_field(split_score)};
            3'd3:    w_glyph = {c_g_d, c_g_blank, f_field(dealer_score)};
            3'd4:    w_glyph = {c_g_a, c_g_blank, f_field({1'b0, coin})};
            default: w_glyph = {4{c_g_blank}};
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= c_st_idle;
            r_cnt          <= '0;
            r_ptr          <= 3'd4;
            r_sel          <= 3'd0;
            page           <= c_no_page;
            page_start     <= 1'b0;
            {d3, d2, d1, d0} <= {4{c_g_blank}};
        end else begin
            page_start <= 1'b0;
            if (w_load) begin
                // Snapshot the source at page entry; later source changes
                // are not reflected until the next load.
                r_state          <= c_st_show;
                r_cnt            <= '0;
                r_ptr            <= w_load_idx;
                page             <= w_load_idx;
                page_start       <= 1'b1;
                {d3, d2, d1, d0} <= w_glyph;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (|req) begin
                            r_sel   <= w_sel;
                            r_state <= c_st_arm;
                        end
                    end
                    c_st_show: begin
                        if (!freeze) begin
                            if (r_cnt == c_cnt_last) begin
                                // Dwell expired with nobody requesting.
                                r_state          <= c_st_idle;
                                r_cnt            <= '0;
                                page             <= c_no_page;
                                {d3, d2, d1, d0} <= {4{c_g_blank}};
                            end else begin
                                r_cnt <= r_cnt + 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_st_idle;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_display_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_display_scheduler
//  Purpose  : Directed self-checking bench for display_scheduler (DWELL=4).
//             Expected pages are queued as stimulus is applied and popped on
//             each page_start; the held display is checked every cycle.
//  Revision : 1.0  initial release
// ============================================================================
module tb_display_scheduler;

    logic       clk;
    logic       reset;
    logic [4:0] req;
    logic       freeze;
    logic [3:0] bet;
    logic [5:0] player_score, player_card, split_score, split_card, dealer_score;
    logic [4:0] coin;
    logic [3:0] d3, d2, d1, d0;
    logic [2:0] page;
    logic       page_start;

    display_scheduler #(.DWELL(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .freeze       (freeze),
        .bet          (bet),
        .player_score (player_score),
        .player_card  (player_card),
        .split_score  (split_score),
        .split_card   (split_card),
        .dealer_score (dealer_score),
        .coin         (coin),
        .d3           (d3),
        .d2           (d2),
        .d1           (d1),
        .d0           (d0),
        .page         (page),
        .page_start   (page_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  pg;
        logic [15:0] dig;
    } exp_t;

    exp_t q[$];
    exp_t cur;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    int   last_start = 0;
    int   last_gap = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [2:0] p, input logic [15:0] d);
        exp_t e;
        e.pg  = p;
        e.dig = d;
        q.push_back(e);
    endtask

    // One clock: sample on the falling edge, then score.
    task automatic tick();
        @(negedge clk);
        cyc++;
        if (page_start) begin
            last_gap   = cyc - last_start;
            last_start = cyc;
            if (q.size() > 0) begin
                cur = q.pop_front();
                chk("page_id", 32'(page), 32'(cur.pg));
                chk("page_digits", 32'({d3, d2, d1, d0}), 32'(cur.dig));
            end else begin
                chk("spurious_page_start", 32'(page_start), 32'h0);
            end
        end
        if (page == 3'd7) begin
            chk("idle_blank", 32'({d3, d2, d1, d0}), 32'hDDDD);
        end else begin
            chk("held_page", 32'(page), 32'(cur.pg));
            chk("held_digits", 32'({d3, d2, d1, d0}), 32'(cur.dig));
        end
    endtask

    task automatic wait_start(input string tag, input int exp_ticks);
        int n = 0;
        bit seen = 1'b0;
        while (!seen && n < 40) begin
            tick();
            n++;
            seen = page_start;
        end
        if (!seen) chk({tag, "_timeout"}, 32'(page_start), 32'h1);
        else       chk({tag, "_ticks"}, 32'(n), 32'(exp_ticks));
    endtask

    initial begin
        cur          = '{pg: 3'd7, dig: 16'hDDDD};
        reset        = 1'b1;
        req          = 5'b00000;
        freeze       = 1'b0;
        bet          = 4'd12;
        player_card  = 6'd10;
        player_score = 6'd21;
        split_card   = 6'd3;
        split_score  = 6'd14;
        dealer_score = 6'd17;
        coin         = 5'd7;
        repeat (2) @(negedge clk);
        reset = 1'b0;

        // Reset state and idle with no requests.
        chk("reset_page", 32'(page), 32'h7);
        chk("reset_digits", 32'({d3, d2, d1, d0}), 32'hDDDD);
        chk("reset_start", 32'(page_start), 32'h0);
        repeat (20) tick();

        // First page from IDLE: two edges of latency.
        req = 5'b00001;
        push(3'd0, 16'hAD12);
        tick();
        chk("idle_latency_page", 32'(page), 32'h7);
        wait_start("bet_first", 1);

        // Alternating player / coin pages.
        req = 5'b10010;
        push(3'd1, 16'h1021);
        push(3'd4, 16'hCDD7);
        push(3'd1, 16'h1021);
        push(3'd4, 16'hCDD7);
        wait_start("rr_player_a", 4);
        wait_start("rr_coin_a", 4);
        wait_start("rr_player_b", 4);
        wait_start("rr_coin_b", 4);

        // Dealer snapshot: mid-page source change is not shown until reload.
        req          = 5'b01000;
        dealer_score = 6'd17;
        push(3'd3, 16'hBD17);
        wait_start("dealer_17", 4);
        tick();
        dealer_score = 6'd22;
        push(3'd3, 16'hBD22);
        wait_start("dealer_22", 3);
        chk("dealer_gap", 32'(last_gap), 32'd4);

        // Freeze for three cycles stretches the page to seven.
        push(3'd3, 16'hBD22);
        tick();
        freeze = 1'b1;
        repeat (3) tick();
        freeze = 1'b0;
        wait_start("freeze_resume", 3);
        chk("freeze_gap", 32'(last_gap), 32'd7);

        // Dropping the request mid-page lets the page finish, then IDLE.
        tick();
        req = 5'b00000;
        tick();
        tick();
        chk("drop_still_shown", 32'(page), 32'h3);
        tick();
        chk("drop_to_idle", 32'(page), 32'h7);
        freeze = 1'b1;
        repeat (5) tick();
        freeze = 1'b0;

        // Bring up a coin page, then reset asynchronously mid-page.
        coin = 5'd31;
        bet  = 4'd5;
        req  = 5'b11111;
        push(3'd4, 16'hCD31);
        wait_start("coin_from_idle", 2);
        tick();
        #2 reset = 1'b1;
        #1;
        chk("async_reset_page", 32'(page), 32'h7);
        chk("async_reset_digits", 32'({d3, d2, d1, d0}), 32'hDDDD);
        chk("async_reset_start", 32'(page_start), 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // After reset the search begins at the bet source.
        push(3'd0, 16'hADD5);
        push(3'd1, 16'h1021);
        push(3'd2, 16'hD314);
        push(3'd3, 16'hBD22);
        push(3'd4, 16'hCD31);
        push(3'd0, 16'hADD5);
        wait_start("post_reset_bet", 2);
        wait_start("post_reset_player", 4);
        wait_start("post_reset_split", 4);
        wait_start("post_reset_dealer", 4);
        wait_start("post_reset_coin", 4);
        wait_start("post_reset_wrap", 4);
        chk("queue_drained", 32'(q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
